// File: rtl/pipeline_types.sv
// Shared types for the LED node pipeline stages.
// Decoder output bundle, pixel type and frame controller states.
package pipeline_types;

   localparam int DEFAULT_BITS_PER_PIXEL = 24;
   localparam int PIXEL_WIDTH = 24;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      FORWARD
   } frame_ctrl_state_e;

   typedef struct packed {
      logic decoded_bit;
      logic valid;
      logic treset;
   } shift_reg_t;

endpackage

// File: rtl/frame_controller_pixel_assembler.sv
// Staging shift register and bit counter for one GRB pixel.
// full flags the shift that completes the pixel.
module pixel_assembler
   import pipeline_types::*;
#(
   parameter int BITS_PER_PIXEL = DEFAULT_BITS_PER_PIXEL
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   shift,
   input  logic   clear,
   input  logic   data,
   output pixel_t staging,
   output logic   full
);

   localparam int CW = $clog2(BITS_PER_PIXEL + 1);

   logic [CW-1:0] count;

   assign full = shift && (count == CW'(BITS_PER_PIXEL - 1));

   // Shift bits in MSB-first; clear drops any partial pixel.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         staging <= '0;
         count   <= '0;
      end else if (shift) begin
         staging <= {staging[PIXEL_WIDTH-2:0], data};
         count   <= count + 1'b1;
      end
   end

endmodule

// File: rtl/frame_controller.sv
// WS2812 frame sequencer: capture one pixel, forward the rest,
// latch the pixel on the line reset interval.
module frame_controller
   import pipeline_types::*;
#(
   parameter int BITS_PER_PIXEL  = DEFAULT_BITS_PER_PIXEL,
   parameter int FWD_CNT_WIDTH   = 16,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  shift_reg_t                 i_shift_reg,
   output pixel_t                     o_pixel,
   output logic                       o_pixel_valid,
   output logic                       o_forward_en,
   output logic                       o_error,
   output logic [FWD_CNT_WIDTH-1:0]   o_fwd_count,
   output logic [FRAME_CNT_WIDTH-1:0] o_frame_count
);

   frame_ctrl_state_e state;
   pixel_t            staging;
   logic              shift;
   logic              clear;
   logic              full;

   // treset always wins over a coincident valid bit.
   assign clear = i_shift_reg.treset;
   assign shift = i_shift_reg.valid && !i_shift_reg.treset
                  && (state != FORWARD);

   pixel_assembler #(
      .BITS_PER_PIXEL(BITS_PER_PIXEL)
   ) u_asm (
      .clk    (i_clk),
      .reset  (i_reset),
      .shift  (shift),
      .clear  (clear),
      .data   (i_shift_reg.decoded_bit),
      .staging(staging),
      .full   (full)
   );

   // Frame FSM with registered outputs and counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         o_pixel       <= '0;
         o_pixel_valid <= 1'b0;
         o_forward_en  <= 1'b0;
         o_error       <= 1'b0;
         o_fwd_count   <= '0;
         o_frame_count <= '0;
      end else begin
         o_pixel_valid <= 1'b0;
         o_error       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (shift) begin
                  if (full) begin
                     state        <= FORWARD;
                     o_forward_en <= 1'b1;
                     o_fwd_count  <= '0;
                  end else begin
                     state <= CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (i_shift_reg.treset) begin
                  o_error <= 1'b1;
                  state   <= IDLE;
               end else if (full) begin
                  state        <= FORWARD;
                  o_forward_en <= 1'b1;
                  o_fwd_count  <= '0;
               end
            end
            FORWARD: begin
               if (i_shift_reg.treset) begin
                  o_pixel       <= staging;
                  o_pixel_valid <= 1'b1;
                  o_frame_count <= o_frame_count + 1'b1;
                  o_forward_en  <= 1'b0;
                  state         <= IDLE;
               end else if (i_shift_reg.valid
                            && (o_fwd_count != '1)) begin
                  o_fwd_count <= o_fwd_count + 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               o_forward_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
